// File: rtl/chan_scheduler_pkg.sv
// Shared types and constants for the channel scheduler.
// Holds requester count, select width, FSM state encoding and a one-hot helper.
package chan_scheduler_pkg;

    localparam int unsigned NUM_REQ = 4;
    localparam int unsigned SEL_W   = 2;

    typedef enum logic [1:0] {
        IDLE,
        HOLD,
        GAP
    } state_t;

    // Select index to one-hot requester mask
    function automatic logic [NUM_REQ-1:0] onehot(input logic [SEL_W-1:0] sel);
        logic [NUM_REQ-1:0] mask;
        mask      = '0;
        mask[sel] = 1'b1;
        return mask;
    endfunction

endpackage

// File: rtl/chan_scheduler_if.sv
// Request/select bundle between requesters and the channel scheduler.
// Signals: req, req_dest, lock (requester side), mux_sel, demux_sel, chan_en,
// grant, done, busy (scheduler side).
// master: requester / test side; slave: the scheduler.
interface chan_scheduler_if;
    import chan_scheduler_pkg::*;

    logic [NUM_REQ-1:0]       req;
    logic [SEL_W*NUM_REQ-1:0] req_dest;
    logic                     lock;
    logic [SEL_W-1:0]         mux_sel;
    logic [SEL_W-1:0]         demux_sel;
    logic                     chan_en;
    logic [NUM_REQ-1:0]       grant;
    logic [NUM_REQ-1:0]       done;
    logic                     busy;

    modport master (
        output req, req_dest, lock,
        input  mux_sel, demux_sel, chan_en, grant, done, busy
    );

    modport slave (
        input  req, req_dest, lock,
        output mux_sel, demux_sel, chan_en, grant, done, busy
    );

endinterface

// File: rtl/chan_scheduler_rr_pick.sv
// Combinational round-robin picker.
// Ports: req (request mask), last (previous owner) -> valid (any request),
// idx (first set request scanning last+1, last+2, ... modulo NUM_REQ).
module rr_pick
    import chan_scheduler_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               valid,
    output logic [SEL_W-1:0]   idx
);

    // Scan from farthest to nearest so the nearest candidate after 'last' wins
    always_comb begin
        logic [SEL_W-1:0] cand;
        valid = 1'b0;
        idx   = last;
        cand  = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = last + SEL_W'(k);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/chan_scheduler.sv
// Round-robin time-multiplexing controller for the shared 4-bit channel.
// Ports: clk, rst (sync, active-high), bus (chan_scheduler_if.slave):
//   req/req_dest/lock in; mux_sel/demux_sel/chan_en/grant/done/busy out.
// Parameters: HOLD_CYCLES (slot length, >=1), GAP_CYCLES (idle gap, >=0),
//   CNT_W (counter width).
// Optional feature: define CHAN_SCHED_LOCK_EN to let the owner extend its
//   slot by holding lock and its request at the end of the slot.
module chan_scheduler
    import chan_scheduler_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 1,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    chan_scheduler_if.slave   bus
);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   last_q, last_d;
    logic [SEL_W-1:0]   mux_q, mux_d;
    logic [SEL_W-1:0]   demux_q, demux_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic               chan_en_q, chan_en_d;
    logic               busy_q, busy_d;

    logic               pick_valid;
    logic [SEL_W-1:0]   pick_idx;
    logic               extend;

    rr_pick u_rr_pick (
        .req   (bus.req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // Slot extension request; mux_q names the current owner during HOLD
`ifdef CHAN_SCHED_LOCK_EN
    assign extend   = bus.lock & bus.req[mux_q];
    assign bus.done = extend ? '0 : done_q;
`else
    logic unused_lock;
    assign unused_lock = bus.lock;
    assign extend      = 1'b0;
    assign bus.done    = done_q;
`endif

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_q    <= SEL_W'(NUM_REQ - 1);
            mux_q     <= '0;
            demux_q   <= '0;
            grant_q   <= '0;
            done_q    <= '0;
            chan_en_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            mux_q     <= mux_d;
            demux_q   <= demux_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            chan_en_q <= chan_en_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last_d    = last_q;
        mux_d     = mux_q;
        demux_d   = demux_q;
        grant_d   = grant_q;
        chan_en_d = chan_en_q;

        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    mux_d     = pick_idx;
                    demux_d   = bus.req_dest[{pick_idx, 1'b0} +: SEL_W];
                    grant_d   = onehot(pick_idx);
                    chan_en_d = 1'b1;
                    cnt_d     = CNT_W'(HOLD_CYCLES - 1);
                    state_d   = HOLD;
                end
            end
            HOLD: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else if (extend) begin
                    cnt_d = CNT_W'(HOLD_CYCLES - 1);
                end else begin
                    chan_en_d = 1'b0;
                    grant_d   = '0;
                    last_d    = mux_q;
                    if (GAP_CYCLES > 0) begin
                        cnt_d   = CNT_W'(GAP_CYCLES - 1);
                        state_d = GAP;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // done is registered one edge early: it marks the cycle whose cnt is 0
        done_d = (state_d == HOLD && cnt_d == '0) ? grant_d : '0;
        busy_d = (state_d != IDLE);
    end

    assign bus.mux_sel   = mux_q;
    assign bus.demux_sel = demux_q;
    assign bus.chan_en   = chan_en_q;
    assign bus.grant     = grant_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_chan_scheduler.sv
// Scoreboard bench for chan_scheduler: two instances (HOLD=4/GAP=1 and
// HOLD=2/GAP=0) share stimulus; a slot-level reference model predicts the
// outputs after every edge and a negedge monitor compares them.
module tb_chan_scheduler;
    import chan_scheduler_pkg::*;

    localparam int NDUT = 2;
    localparam int H0 = 4;
    localparam int G0 = 1;
    localparam int H1 = 2;
    localparam int G1 = 0;

    typedef struct {
        int         d;
        int         cyc;
        logic [3:0] grant;
        logic [1:0] mux_sel;
        logic [1:0] demux_sel;
        logic       chan_en;
        logic [3:0] done;
        logic       busy;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [7:0] req_dest;
    logic       lock;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t exp_q[$];

    chan_scheduler_if bus0 ();
    chan_scheduler_if bus1 ();

    assign bus0.req      = req;
    assign bus0.req_dest = req_dest;
    assign bus0.lock     = lock;
    assign bus1.req      = req;
    assign bus1.req_dest = req_dest;
    assign bus1.lock     = lock;

    chan_scheduler #(.HOLD_CYCLES(H0), .GAP_CYCLES(G0), .CNT_W(8)) dut0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0.slave)
    );

    chan_scheduler #(.HOLD_CYCLES(H1), .GAP_CYCLES(G1), .CNT_W(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    logic [3:0] a_grant [NDUT];
    logic [1:0] a_mux   [NDUT];
    logic [1:0] a_demux [NDUT];
    logic       a_en    [NDUT];
    logic [3:0] a_done  [NDUT];
    logic       a_busy  [NDUT];

    assign a_grant[0] = bus0.grant;
    assign a_mux[0]   = bus0.mux_sel;
    assign a_demux[0] = bus0.demux_sel;
    assign a_en[0]    = bus0.chan_en;
    assign a_done[0]  = bus0.done;
    assign a_busy[0]  = bus0.busy;
    assign a_grant[1] = bus1.grant;
    assign a_mux[1]   = bus1.mux_sel;
    assign a_demux[1] = bus1.demux_sel;
    assign a_en[1]    = bus1.chan_en;
    assign a_done[1]  = bus1.done;
    assign a_busy[1]  = bus1.busy;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int hold_of(input int d);
        return (d == 0) ? H0 : H1;
    endfunction

    function automatic int gap_of(input int d);
        return (d == 0) ? G0 : G1;
    endfunction

    task automatic check(input string name, input int d, input int cyc,
                         input logic [7:0] act, input logic [7:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h",
                     name, d, cyc, act, expv);
        end
    endtask

    // Reference model: a slot starts at the edge where an idle scheduler sees
    // any request; it shows chan_en for HOLD edges, idles for GAP edges, and
    // needs one more idle edge before the next arbitration.
    initial begin
        int         edge_n;
        bit         seen_rst;
        int         last      [NDUT];
        int         next_free [NDUT];
        int         start     [NDUT];
        int         idx       [NDUT];
        bit         in_slot   [NDUT];
        logic [1:0] m_mux     [NDUT];
        logic [1:0] m_demux   [NDUT];
        exp_t       e;
        edge_n   = 0;
        seen_rst = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            last[d] = 3; next_free[d] = 0; start[d] = 0; idx[d] = 0;
            in_slot[d] = 1'b0; m_mux[d] = '0; m_demux[d] = '0;
        end
        forever begin
            @(posedge clk);
            edge_n++;
            if (rst) seen_rst = 1'b1;
            if (seen_rst) begin
                for (int d = 0; d < NDUT; d++) begin
                    if (rst) begin
                        last[d]      = 3;
                        next_free[d] = edge_n + 1;
                        in_slot[d]   = 1'b0;
                        m_mux[d]     = '0;
                        m_demux[d]   = '0;
                    end else if (edge_n >= next_free[d] && req != 4'b0) begin
                        int  win;
                        bit  found;
                        win   = 0;
                        found = 1'b0;
                        for (int k = 1; k <= 4; k++) begin
                            if (!found && req[(last[d] + k) % 4]) begin
                                win   = (last[d] + k) % 4;
                                found = 1'b1;
                            end
                        end
                        idx[d]       = win;
                        m_mux[d]     = 2'(win);
                        m_demux[d]   = 2'((req_dest >> (2 * win)) & 8'h3);
                        start[d]     = edge_n;
                        in_slot[d]   = 1'b1;
                        next_free[d] = edge_n + hold_of(d) + gap_of(d) + 1;
                        last[d]      = win;
                    end
                    e.d         = d;
                    e.cyc       = edge_n;
                    e.grant     = '0;
                    e.mux_sel   = m_mux[d];
                    e.demux_sel = m_demux[d];
                    e.chan_en   = 1'b0;
                    e.done      = '0;
                    e.busy      = 1'b0;
                    if (in_slot[d] && edge_n < start[d] + hold_of(d) + gap_of(d)) begin
                        e.busy = 1'b1;
                        if (edge_n < start[d] + hold_of(d)) begin
                            e.chan_en = 1'b1;
                            e.grant   = 4'(1 << idx[d]);
                            if (edge_n == start[d] + hold_of(d) - 1) e.done = e.grant;
                        end
                    end
                    exp_q.push_back(e);
                end
            end
        end
    end

    // Monitor: compare registered outputs on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("grant",     e.d, e.cyc, 8'(a_grant[e.d]), 8'(e.grant));
                check("mux_sel",   e.d, e.cyc, 8'(a_mux[e.d]),   8'(e.mux_sel));
                check("demux_sel", e.d, e.cyc, 8'(a_demux[e.d]), 8'(e.demux_sel));
                check("chan_en",   e.d, e.cyc, 8'(a_en[e.d]),    8'(e.chan_en));
                check("done",      e.d, e.cyc, 8'(a_done[e.d]),  8'(e.done));
                check("busy",      e.d, e.cyc, 8'(a_busy[e.d]),  8'(e.busy));
            end
        end
    end

    // Stimulus: directed scenarios followed by random traffic
    initial begin
        rst = 1'b1; req = '0; req_dest = '0; lock = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Single requester 0 to destination 2
        req = 4'b0001; req_dest = 8'h02;
        repeat (2) @(negedge clk);
        req = '0;
        repeat (10) @(negedge clk);

        // All requesters held: round-robin rotation
        req = 4'b1111; req_dest = 8'hE4;
        repeat (30) @(negedge clk);
        req = '0;
        repeat (8) @(negedge clk);

        // Requester 2: destination change and request drop mid-slot
        req = 4'b0100; req_dest = 8'h30;
        repeat (2) @(negedge clk);
        req_dest = 8'h10; req = '0;
        repeat (8) @(negedge clk);

        // Reset during the second HOLD cycle, then requesters 1 and 3
        req = 4'b0001; req_dest = 8'h03;
        repeat (2) @(negedge clk);
        rst = 1'b1; req = 4'b1010; req_dest = 8'h9C;
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        req = '0;
        repeat (6) @(negedge clk);

        // Random traffic, lock toggling (ignored), occasional reset
        for (int c = 0; c < 600; c++) begin
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 2) == 0) req_dest = 8'($urandom);
            lock = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        rst = 1'b0; req = '0;
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
